// File: rtl/timer_alarm_sched_pkg.sv
// Shared types and constants for the 100 us alarm scheduler.
// The periodic feature is enabled by defining TIMER_SCHED_PERIODIC_EN.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    LATCH   = 2'd0,
    CAPTURE = 2'd1,
    GRANT   = 2'd2,
    SCAN    = 2'd3
  } sched_state_e;

  localparam int unsigned CW_DEF    = 16;
  localparam int unsigned DELAY_MIN = 1;
  localparam int unsigned DELAY_MAX = (1 << (CW_DEF - 1)) - 1;

endpackage

// File: rtl/timer_alarm_sched_if.sv
// Bundle of timer latch port and per-channel request/alarm signals.
// master = timer + requesters side, slave = the scheduler.
interface timer_alarm_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CW     = 16
);
  logic                 timer_read;
  logic [CW-1:0]        timer_count;
  logic [NUM_CH-1:0]    req_valid;
  logic [NUM_CH*CW-1:0] req_delay;
  logic [NUM_CH-1:0]    req_periodic;
  logic [NUM_CH-1:0]    req_ready;
  logic [NUM_CH-1:0]    cancel;
  logic [NUM_CH-1:0]    armed;
  logic [NUM_CH-1:0]    expire;

  modport master (
    input  timer_read, req_ready, armed, expire,
    output timer_count, req_valid, req_delay, req_periodic, cancel
  );

  modport slave (
    output timer_read, req_ready, armed, expire,
    input  timer_count, req_valid, req_delay, req_periodic, cancel
  );
endinterface

// File: rtl/timer_alarm_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at the pointer,
// pointer moves to winner+1 only when a grant is issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] cand_s;
  logic          found_s;
  logic          hit_s;

  // Pick the first requester at or after the pointer, wrapping once.
  always_comb begin
    gnt_o   = '0;
    ptr_d   = ptr_q;
    found_s = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s        = PW'((int'(ptr_q) + k) % N);
      hit_s         = en_i && !found_s && req_i[cand_s];
      gnt_o[cand_s] = hit_s;
      found_s       = found_s | hit_s;
      ptr_d         = hit_s ? ((cand_s == PW'(N - 1)) ? '0 : cand_s + 1'b1) : ptr_d;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/timer_alarm_sched.sv
// Alarm scheduler sharing one latched tick counter among NUM_CH channels.
// Define TIMER_SCHED_PERIODIC_EN to enable periodic re-arming.
module timer_alarm_sched
  import timer_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = CW_DEF
) (
  input logic                clk,
  input logic                reset,
  timer_alarm_sched_if.slave bus
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] DMIN_C = CW'(DELAY_MIN);
  localparam logic [CW-1:0] DMAX_C = (CW == int'(CW_DEF)) ? CW'(DELAY_MAX)
                                                          : {1'b0, {(CW-1){1'b1}}};

  function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] d);
    logic [CW-1:0] r;
    if (d[CW-1]) begin
      r = DMAX_C;
    end else if (d == '0) begin
      r = DMIN_C;
    end else begin
      r = d;
    end
    return r;
  endfunction

  sched_state_e      state_q;
  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     now_q;
  logic              timer_read_q;
  logic [NUM_CH-1:0] req_ready_q;
  logic [NUM_CH-1:0] expire_q;
  logic [NUM_CH-1:0] armed_q;
  logic [NUM_CH-1:0] armed_d;
  logic [CW-1:0]     deadline_q [NUM_CH];
`ifdef TIMER_SCHED_PERIODIC_EN
  logic [CW-1:0]     period_q [NUM_CH];
  logic [NUM_CH-1:0] periodic_q;
`endif

  logic [NUM_CH-1:0] gnt_s;
  logic [CW-1:0]     delay_s [NUM_CH];
  logic [CW-1:0]     diff_s;
  logic              due_s;
  logic              periodic_sel_s;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == GRANT),
    .req_i (bus.req_valid & ~bus.cancel),
    .gnt_o (gnt_s)
  );

  // Clamped delays, scan compare and next armed vector (cancel wins last).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      delay_s[i] = clamp_delay(bus.req_delay[i*CW +: CW]);
    end
    diff_s = now_q - deadline_q[idx_q];
    due_s  = (state_q == SCAN) && armed_q[idx_q] && !diff_s[CW-1] && !bus.cancel[idx_q];
`ifdef TIMER_SCHED_PERIODIC_EN
    periodic_sel_s = periodic_q[idx_q];
`else
    periodic_sel_s = 1'b0;
`endif
    armed_d        = armed_q | gnt_s;
    armed_d[idx_q] = armed_d[idx_q] & ~(due_s & ~periodic_sel_s);
    armed_d        = armed_d & ~bus.cancel;
  end

  // Pass sequencer: LATCH -> CAPTURE -> GRANT -> SCAN x NUM_CH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LATCH;
      idx_q        <= '0;
      now_q        <= '0;
      timer_read_q <= 1'b0;
      req_ready_q  <= '0;
      expire_q     <= '0;
      armed_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        deadline_q[i] <= '0;
`ifdef TIMER_SCHED_PERIODIC_EN
        period_q[i]   <= '0;
`endif
      end
`ifdef TIMER_SCHED_PERIODIC_EN
      periodic_q <= '0;
`endif
    end else begin
      timer_read_q <= 1'b0;
      req_ready_q  <= gnt_s;
      expire_q     <= '0;
      armed_q      <= armed_d;
      case (state_q)
        // Straight out of reset the strobe is raised one cycle late.
        LATCH: begin
          if (timer_read_q) begin
            state_q <= CAPTURE;
          end else begin
            timer_read_q <= 1'b1;
          end
        end
        CAPTURE: begin
          now_q   <= bus.timer_count;
          state_q <= GRANT;
        end
        GRANT: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_s[i]) begin
              deadline_q[i] <= now_q + delay_s[i];
`ifdef TIMER_SCHED_PERIODIC_EN
              period_q[i]   <= delay_s[i];
              periodic_q[i] <= bus.req_periodic[i];
`endif
            end
          end
          idx_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (due_s) begin
            expire_q[idx_q] <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
            if (periodic_q[idx_q]) begin
              deadline_q[idx_q] <= deadline_q[idx_q] + period_q[idx_q];
            end
`endif
          end
          if (idx_q == IW'(NUM_CH - 1)) begin
            state_q      <= LATCH;
            timer_read_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= LATCH;
        end
      endcase
    end
  end

  assign bus.timer_read = timer_read_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.expire     = expire_q;
  assign bus.armed      = armed_q;
endmodule

// File: tb/tb_timer_alarm_sched.sv
// Bench for timer_alarm_sched: directed passes plus random traffic checked
// against an absolute-time alarm model.
module tb_timer_alarm_sched;
  localparam int N = 4;
  localparam int W = 16;
`ifdef TIMER_SCHED_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #40 clk = ~clk;

  timer_alarm_sched_if #(.NUM_CH(N), .CW(W)) bus ();
  timer_alarm_sched #(.NUM_CH(N), .CW(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: deadlines in absolute (unwrapped) ticks.
  longint t_abs;
  bit     m_armed [N];
  longint m_dl    [N];
  longint m_per   [N];
  bit     m_pmode [N];
  bit     m_pend  [N];
  int     m_delay [N];
  bit     m_preq  [N];
  int     m_ptr;
  logic [N-1:0] g_rdy;
  logic [N-1:0] g_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_delay(input int d);
    if (d == 0) return 1;
    if (d >= 32768) return 32767;
    return d;
  endfunction

  function automatic logic [N-1:0] m_armed_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_armed[i];
    return v;
  endfunction

  task automatic set_req(input int ch, input int d, input bit per);
    m_pend[ch]  = 1'b1;
    m_delay[ch] = d;
    m_preq[ch]  = per;
    bus.req_valid[ch]          = 1'b1;
    bus.req_delay[ch*W +: W]   = W'(d);
    bus.req_periodic[ch]       = per;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_armed[i] = 1'b0;
      m_pend[i]  = 1'b0;
    end
    m_ptr = 0;
    bus.req_valid = '0;
  endtask

  // Entered at the negedge of a LATCH cycle with timer_read high; leaves at the next one.
  task automatic do_pass(input int adv, input logic [N-1:0] cg, input logic [N-1:0] cs,
                         input string tag);
    logic [N-1:0] e_rdy, e_exp, o_rdy, o_exp, rdy_multi, exp_multi, sel;
    logic         read_mid;
    int           win;
    t_abs = t_abs + adv;
    bus.timer_count = W'(t_abs & 64'hFFFF);
    e_rdy = '0;
    e_exp = '0;
    win   = -1;
    for (int i = 0; i < N; i++) if (cg[i]) m_armed[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (win < 0 && m_pend[c] && !cg[c]) win = c;
    end
    if (win >= 0) begin
      e_rdy[win]   = 1'b1;
      m_pend[win]  = 1'b0;
      m_armed[win] = 1'b1;
      m_dl[win]    = t_abs + eff_delay(m_delay[win]);
      m_per[win]   = eff_delay(m_delay[win]);
      m_pmode[win] = m_preq[win] && PER_EN;
      m_ptr        = (win + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (cs[i]) begin
        m_armed[i] = 1'b0;
      end else if (m_armed[i] && t_abs >= m_dl[i]) begin
        e_exp[i] = 1'b1;
        if (m_pmode[i]) m_dl[i] = m_dl[i] + m_per[i];
        else m_armed[i] = 1'b0;
      end
    end
    o_rdy = '0; o_exp = '0; rdy_multi = '0; exp_multi = '0; read_mid = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      rdy_multi = rdy_multi | (o_rdy & bus.req_ready);
      exp_multi = exp_multi | (o_exp & bus.expire);
      o_rdy     = o_rdy | bus.req_ready;
      o_exp     = o_exp | bus.expire;
      if (c < N + 3) read_mid = read_mid | bus.timer_read;
      bus.req_valid = bus.req_valid & ~bus.req_ready;
      sel = '0;
      if (c >= 3 && c <= N + 2) sel[c-3] = 1'b1;
      if (c == 2) bus.cancel = cg;
      else bus.cancel = cs & sel;
    end
    g_rdy = o_rdy;
    g_exp = o_exp;
    check({tag, " ready"},        32'(o_rdy), 32'(e_rdy));
    check({tag, " ready_multi"},  32'(rdy_multi), 32'd0);
    check({tag, " expire"},       32'(o_exp), 32'(e_exp));
    check({tag, " expire_multi"}, 32'(exp_multi), 32'd0);
    check({tag, " armed"},        32'(bus.armed), 32'(m_armed_vec()));
    check({tag, " read_end"},     32'(bus.timer_read), 32'd1);
    check({tag, " read_mid"},     32'(read_mid), 32'd0);
  endtask

  initial begin
    logic [N-1:0] cg, cs;
    int           d;
    reset            = 1'b0;
    bus.timer_count  = '0;
    bus.req_valid    = '0;
    bus.req_delay    = '0;
    bus.req_periodic = '0;
    bus.cancel       = '0;
    t_abs            = 50;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst read",   32'(bus.timer_read), 32'd0);
    check("rst ready",  32'(bus.req_ready), 32'd0);
    check("rst armed",  32'(bus.armed), 32'd0);
    check("rst expire", 32'(bus.expire), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("release read", 32'(bus.timer_read), 32'd1);

    // Arm ch0 with a long delay, then drop reset in the middle of SCAN.
    set_req(0, 1000, 1'b0);
    do_pass(0, '0, '0, "arm0");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst armed",  32'(bus.armed), 32'd0);
    check("midrst read",   32'(bus.timer_read), 32'd0);
    check("midrst expire", 32'(bus.expire), 32'd0);
    check("midrst ready",  32'(bus.req_ready), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rerelease read",  32'(bus.timer_read), 32'd1);
    check("rerelease armed", 32'(bus.armed), 32'd0);

    // Ch1 one-shot, delay 5, armed at count 100.
    t_abs = 100;
    set_req(1, 5, 1'b0);
    do_pass(0, '0, '0, "ch1 arm");
    check("ch1 ready pulse", 32'(g_rdy), 32'h2);
    for (int t = 101; t <= 106; t++) begin
      do_pass(1, '0, '0, "ch1 run");
      check("ch1 fire time", 32'(g_exp), (t == 105) ? 32'h2 : 32'h0);
    end

    // Wrap: arm ch3 at 0xFFFE with delay 4.
    t_abs = 65534;
    set_req(3, 4, 1'b0);
    do_pass(0, '0, '0, "wrap arm");
    for (int k = 1; k <= 5; k++) begin
      do_pass(1, '0, '0, "wrap run");
      check("wrap fire time", 32'(g_exp), (k == 4) ? 32'h8 : 32'h0);
    end

    // All four channels request together.
    for (int i = 0; i < N; i++) set_req(i, 2000 + i, 1'b0);
    for (int p = 0; p < N; p++) begin
      do_pass(1, '0, '0, "contend");
      check("contend order", 32'(g_rdy), 32'd1 << p);
    end

    // Cancel in GRANT blocks the grant and keeps the request pending.
    set_req(0, 3, 1'b0);
    do_pass(1, 4'b1111, '0, "cancel grant");
    check("cancel grant no ready", 32'(g_rdy), 32'h0);
    check("cancel grant pending",  32'(bus.req_valid[0]), 32'd1);
    do_pass(1, '0, '0, "grant ch0");

    // Cancel ch2 in the same cycle as its expiry; ch0 fires that pass too.
    set_req(2, 2, 1'b0);
    do_pass(1, '0, '0, "arm ch2");
    do_pass(1, '0, '0, "wait ch2");
    do_pass(1, '0, 4'b0100, "cancel expire");
    check("cancel expire pulse", 32'(g_exp), 32'h1);
    check("cancel expire armed", 32'(bus.armed[2]), 32'd0);

    // Ch3 periodic, delay 3, armed at count 10.
    t_abs = ((t_abs >> 16) + 1) * 65536 + 10;
    set_req(3, 3, 1'b1);
    do_pass(0, '0, '0, "per arm");
    for (int t = 11; t <= 20; t++) begin
      do_pass(1, '0, '0, "per run");
      check("per fire time", 32'(g_exp[3]),
            (t == 13 || (PER_EN && (t == 16 || t == 19))) ? 32'd1 : 32'd0);
    end
    check("per armed", 32'(bus.armed[3]), PER_EN ? 32'd1 : 32'd0);
    do_pass(0, '0, 4'b1000, "per cancel");
    check("per cancelled", 32'(bus.armed[3]), 32'd0);

    // Random traffic.
    for (int p = 0; p < 80; p++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_pend[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 9))
            0:       d = 0;
            1:       d = 32768 + int'($urandom_range(0, 32767));
            default: d = int'($urandom_range(1, 6));
          endcase
          set_req(i, d, 1'($urandom_range(0, 1)));
        end
      end
      cg = '0;
      cs = '0;
      for (int i = 0; i < N; i++) begin
        cg[i] = ($urandom_range(0, 15) == 0);
        cs[i] = ($urandom_range(0, 15) == 0);
      end
      do_pass(int'($urandom_range(0, 2)), cg, cs, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
